// File: rtl/haz_pkg.sv
// Shared types for the hazard scoreboard: in-flight writer entry and operand-need stage encodings.
package haz_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] rw;
        logic [1:0] avail;
        logic       md;
    } haz_entry_t;

    localparam logic [1:0] HAZ_NEED_ID  = 2'd0;
    localparam logic [1:0] HAZ_NEED_EX  = 2'd1;
    localparam logic [1:0] HAZ_NEED_MEM = 2'd2;

endpackage

// File: rtl/haz_md_timer.sv
// Mul/div busy timer: loads on issue, counts down unless held, cleared when the issuing op is flushed.
module haz_md_timer #(
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic       load,
    input  logic       clear,
    output logic [7:0] md_cnt,
    output logic       md_busy
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (load) begin
            md_cnt <= 8'(MD_LAT);
        end else if (clear) begin
            md_cnt <= '0;
        end else if (!hold && md_cnt != 8'd0) begin
            md_cnt <= md_cnt - 8'd1;
        end
    end

    assign md_busy = (md_cnt != 8'd0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / branch-use / mul-div stall detector over DEPTH in-flight writers.
// Optional HAZ_STORE_FWD_EN: store data (rt) is checked against the MEM-stage forward point.
module hazard_scoreboard
    import haz_pkg::*;
#(
    parameter int DEPTH      = 3,
    parameter int ALU_AVAIL  = 1,
    parameter int LOAD_AVAIL = 2,
    parameter int MD_LAT     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             id_valid,
    input  logic             id_flush,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [1:0]       id_need_stage,
    input  logic             id_is_store,
    input  logic             id_reg_write,
    input  logic [4:0]       id_rw,
    input  logic             id_is_load,
    input  logic             id_md_start,
    input  logic             id_md_read,
    input  logic [DEPTH-1:0] flush_mask,
    output logic             stall,
    output logic             issue,
    output logic             md_busy,
    output logic [2:0]       cause
);

    haz_entry_t [DEPTH-1:0] entry_q;
    haz_entry_t             new_entry;
    logic [7:0]             md_cnt;
    logic                   id_live;
    logic [1:0]             rt_need;
    logic                   rs_haz, rt_haz;
    logic                   id_use_haz, ex_use_haz, md_haz;

    // Youngest matching writer decides; older matches for the same register are shadowed.
    function automatic logic src_hazard(input haz_entry_t [DEPTH-1:0] e,
                                        input logic [4:0] s,
                                        input logic [1:0] n);
        logic hit;
        logic haz;
        hit = 1'b0;
        haz = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!hit && e[i].valid && e[i].rw == s) begin
                hit = 1'b1;
                haz = (i + int'(n)) < int'(e[i].avail);
            end
        end
        return haz && (s != 5'd0);
    endfunction

`ifdef HAZ_STORE_FWD_EN
    assign rt_need = id_is_store ? HAZ_NEED_MEM : id_need_stage;
`else
    logic unused_store;
    assign unused_store = id_is_store;
    assign rt_need      = id_need_stage;
`endif

    assign id_live = id_valid && !id_flush;
    assign rs_haz  = id_use_rs && src_hazard(entry_q, id_rs, id_need_stage);
    assign rt_haz  = id_use_rt && src_hazard(entry_q, id_rt, rt_need);

    assign id_use_haz = id_live && ((rs_haz && id_need_stage == HAZ_NEED_ID) ||
                                    (rt_haz && rt_need == HAZ_NEED_ID));
    assign ex_use_haz = id_live && ((rs_haz && id_need_stage != HAZ_NEED_ID) ||
                                    (rt_haz && rt_need != HAZ_NEED_ID));
    assign md_haz     = id_live && (id_md_read || id_md_start) && md_busy;

    assign stall = hold || id_use_haz || ex_use_haz || md_haz;
    assign issue = id_live && !stall;
    assign cause = {md_haz, id_use_haz, ex_use_haz};

    always_comb begin
        new_entry       = '0;
        new_entry.valid = id_reg_write && (id_rw != 5'd0);
        new_entry.rw    = id_rw;
        new_entry.avail = id_is_load ? 2'(LOAD_AVAIL) : 2'(ALU_AVAIL);
        new_entry.md    = id_md_start;
    end

    // Hold freezes positions but flushes still kill entries in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_q <= '0;
        end else if (hold) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (flush_mask[i]) entry_q[i].valid <= 1'b0;
            end
        end else begin
            entry_q[0] <= issue ? new_entry : '0;
            for (int i = 1; i < DEPTH; i++) begin
                entry_q[i] <= entry_q[i-1];
                if (flush_mask[i-1]) entry_q[i].valid <= 1'b0;
            end
        end
    end

    haz_md_timer #(
        .MD_LAT(MD_LAT)
    ) u_md_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .hold   (hold),
        .load   (issue && id_md_start),
        .clear  (flush_mask[0] && entry_q[0].md),
        .md_cnt (md_cnt),
        .md_busy(md_busy)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected outputs queued per step, checked on the falling edge.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [1:0] need;
        logic       st;
        logic       rwr;
        logic [4:0] rw;
        logic       ld;
        logic       mds;
        logic       mdr;
    } instr_t;

    typedef struct packed {
        logic       stall;
        logic       issue;
        logic [2:0] cause;
        logic       busy;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             hold;
    logic             id_valid, id_flush;
    logic [4:0]       id_rs, id_rt, id_rw;
    logic             id_use_rs, id_use_rt;
    logic [1:0]       id_need_stage;
    logic             id_is_store, id_reg_write, id_is_load, id_md_start, id_md_read;
    logic [DEPTH-1:0] flush_mask;
    logic             stall, issue, md_busy;
    logic [2:0]       cause;

    exp_t  expq[$];
    string tagq[$];
    int    checks   = 0;
    int    failures = 0;

    hazard_scoreboard #(
        .DEPTH(DEPTH), .ALU_AVAIL(1), .LOAD_AVAIL(2), .MD_LAT(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .id_valid(id_valid), .id_flush(id_flush),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_need_stage(id_need_stage), .id_is_store(id_is_store),
        .id_reg_write(id_reg_write), .id_rw(id_rw), .id_is_load(id_is_load),
        .id_md_start(id_md_start), .id_md_read(id_md_read),
        .flush_mask(flush_mask),
        .stall(stall), .issue(issue), .md_busy(md_busy), .cause(cause)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic instr_t nop();
        return '0;
    endfunction
    function automatic instr_t alu(input logic [4:0] rw, input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = '0;
        x.v = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1;
        x.need = 2'd1; x.rwr = 1'b1; x.rw = rw;
        return x;
    endfunction
    function automatic instr_t lw(input logic [4:0] rw, input logic [4:0] base);
        instr_t x = '0;
        x.v = 1'b1; x.rs = base; x.urs = 1'b1; x.need = 2'd1;
        x.rwr = 1'b1; x.rw = rw; x.ld = 1'b1;
        return x;
    endfunction
    function automatic instr_t beq(input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = '0;
        x.v = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1; x.need = 2'd0;
        return x;
    endfunction
    function automatic instr_t sw(input logic [4:0] rt, input logic [4:0] base);
        instr_t x = '0;
        x.v = 1'b1; x.rs = base; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1;
        x.need = 2'd1; x.st = 1'b1;
        return x;
    endfunction
    function automatic instr_t div(input logic [4:0] rs, input logic [4:0] rt);
        instr_t x = '0;
        x.v = 1'b1; x.rs = rs; x.rt = rt; x.urs = 1'b1; x.urt = 1'b1;
        x.need = 2'd1; x.mds = 1'b1;
        return x;
    endfunction
    function automatic instr_t mflo(input logic [4:0] rw);
        instr_t x = '0;
        x.v = 1'b1; x.need = 2'd1; x.rwr = 1'b1; x.rw = rw; x.mdr = 1'b1;
        return x;
    endfunction

    task automatic drive(input instr_t in, input logic h, input logic [DEPTH-1:0] fm, input logic fl);
        id_valid = in.v;  id_rs = in.rs;  id_rt = in.rt;
        id_use_rs = in.urs; id_use_rt = in.urt; id_need_stage = in.need;
        id_is_store = in.st; id_reg_write = in.rwr; id_rw = in.rw;
        id_is_load = in.ld; id_md_start = in.mds; id_md_read = in.mdr;
        hold = h; flush_mask = fm; id_flush = fl;
    endtask

    task automatic expect_out(input logic es, input logic ei, input logic [2:0] ec,
                              input logic eb, input string tag);
        expq.push_back('{stall: es, issue: ei, cause: ec, busy: eb});
        tagq.push_back(tag);
    endtask

    task automatic check_out();
        exp_t  e;
        string t;
        e = expq.pop_front();
        t = tagq.pop_front();
        checks++;
        assert (stall === e.stall) else begin
            failures++;
            $error("FAIL %s stall observed=%b expected=%b", t, stall, e.stall);
        end
        checks++;
        assert (issue === e.issue) else begin
            failures++;
            $error("FAIL %s issue observed=%b expected=%b", t, issue, e.issue);
        end
        checks++;
        assert (cause === e.cause) else begin
            failures++;
            $error("FAIL %s cause observed=%b expected=%b", t, cause, e.cause);
        end
        checks++;
        assert (md_busy === e.busy) else begin
            failures++;
            $error("FAIL %s md_busy observed=%b expected=%b", t, md_busy, e.busy);
        end
    endtask

    task automatic cyc(input instr_t in, input logic h, input logic [DEPTH-1:0] fm, input logic fl,
                       input logic es, input logic ei, input logic [2:0] ec, input logic eb,
                       input string tag);
        drive(in, h, fm, fl);
        expect_out(es, ei, ec, eb, tag);
        @(negedge clk);
        check_out();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(nop(), 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        expect_out(1'b0, 1'b0, 3'b000, 1'b0, "reset");
        @(negedge clk);
        check_out();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use with EX consumer: one bubble
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw_issue");
        cyc(alu(9, 8, 1), 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, "addu_stall");
        cyc(alu(9, 8, 1), 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "addu_issue");

        // ALU result consumed by branch in ID: one bubble
        cyc(beq(9, 0),    1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, "beq_alu_stall");
        cyc(beq(9, 0),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "beq_alu_go");

        // load consumed by branch in ID: two bubbles
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw2_issue");
        cyc(beq(8, 0),    1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, "beq_lw_stall1");
        cyc(beq(8, 0),    1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b010, 1'b0, "beq_lw_stall2");
        cyc(beq(8, 0),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "beq_lw_go");

        // load followed by store of the loaded register
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw3_issue");
`ifdef HAZ_STORE_FWD_EN
        cyc(sw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "sw_fwd_go");
`else
        cyc(sw(8, 2),     1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, "sw_stall");
        cyc(sw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "sw_go");
`endif
        for (int i = 0; i < 3; i++)
            cyc(nop(),    1'b0, '0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, "idle");

        // div then mflo: stalls for the full latency
        cyc(div(4, 5),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "div_issue");
        for (int i = 0; i < 32; i++)
            cyc(mflo(10), 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, "mflo_busy");
        cyc(mflo(10),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "mflo_issue");

        // div killed in EX clears the timer
        cyc(div(4, 5),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "div2_issue");
        cyc(nop(),        1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 3'b000, 1'b1, "div_flush");
        cyc(mflo(10),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "mflo_after_flush");

        // external hold freezes the scoreboard
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw4_issue");
        for (int i = 0; i < 5; i++)
            cyc(alu(9, 8, 1), 1'b1, '0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, "hold");
        cyc(alu(9, 8, 1), 1'b0, '0, 1'b0, 1'b1, 1'b0, 3'b001, 1'b0, "post_hold_stall");
        cyc(alu(9, 8, 1), 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "post_hold_go");

        // flushed ID masks hazards; flush_mask kills the load in EX
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw5_issue");
        cyc(beq(8, 0),    1'b0, 3'b001, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, "id_flush_mask");
        cyc(beq(8, 0),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "flush_mask_kill");

        // writes to r0 never create hazards
        cyc(alu(0, 1, 1), 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "r0_write");
        cyc(beq(0, 0),    1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "r0_read");

        // asynchronous reset during a stall
        cyc(lw(8, 2),     1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "lw6_issue");
        drive(alu(9, 8, 1), 1'b0, '0, 1'b0);
        expect_out(1'b1, 1'b0, 3'b001, 1'b0, "pre_reset_stall");
        @(negedge clk);
        check_out();
        #2;
        rst_n = 1'b0;
        expect_out(1'b0, 1'b1, 3'b000, 1'b0, "reset_mid_stall");
        #1;
        check_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(alu(9, 8, 1), 1'b0, '0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
